// File: rtl/qe_m_arbiter_if.sv
// Bundle of every handshake and data signal around qe_m_arbiter.
// The slave view belongs to the arbiter; the master view belongs to whatever
// drives the two requesters and models the shared QE_M unit.
interface qe_m_arbiter_if #(
    parameter int DW = 8,
    parameter int RW = 16
);
    // requester 0
    logic          req0_valid;
    logic          req0_ready;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic [DW-1:0] req0_c;
    logic [DW-1:0] req0_x;
    logic          req0_mode;
    logic          req0_last;

    // requester 1
    logic          req1_valid;
    logic          req1_ready;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic [DW-1:0] req1_c;
    logic [DW-1:0] req1_x;
    logic          req1_mode;
    logic          req1_last;

    // shared QE_M unit
    logic [DW-1:0] qe_a;
    logic [DW-1:0] qe_b;
    logic [DW-1:0] qe_c;
    logic [DW-1:0] qe_x;
    logic          qe_mode;
    logic          qe_valid_in;
    logic          qe_last_input;
    logic          qe_valid_out;
    logic [RW-1:0] qe_result;

    // responses and status
    logic          rsp0_valid;
    logic [RW-1:0] rsp0_result;
    logic          rsp1_valid;
    logic [RW-1:0] rsp1_result;
    logic          err_underflow;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_c, req0_x, req0_mode, req0_last,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_c, req1_x, req1_mode, req1_last,
        output req1_ready,
        output qe_a, qe_b, qe_c, qe_x, qe_mode, qe_valid_in, qe_last_input,
        input  qe_valid_out, qe_result,
        output rsp0_valid, rsp0_result, rsp1_valid, rsp1_result, err_underflow
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_c, req0_x, req0_mode, req0_last,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_c, req1_x, req1_mode, req1_last,
        input  req1_ready,
        input  qe_a, qe_b, qe_c, qe_x, qe_mode, qe_valid_in, qe_last_input,
        output qe_valid_out, qe_result,
        input  rsp0_valid, rsp0_result, rsp1_valid, rsp1_result, err_underflow
    );
endinterface

// File: rtl/qe_m_arbiter.sv
// Two-requester front end for one QE_M unit.
// Round-robin grant per transaction, grant locked across a MAC sequence,
// registered issue to QE_M, and an ID tag FIFO that steers each QE_M result
// back to the requester that issued it (QE_M returns results in issue order).
module qe_m_arbiter #(
    parameter int DW        = 8,
    parameter int RW        = 16,
    parameter int TAG_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    qe_m_arbiter_if.slave bus
);
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);

    typedef enum logic {
        ST_ARB,
        ST_LOCK
    } state_t;

    state_t        state, state_d;
    logic          last_grant, last_grant_d;  // 1 means requester 1 was served last
    logic          owner, owner_d;            // requester holding the MAC lock

    logic          grant0, grant1;
    logic          room;
    logic          acc0, acc1, accept, sel_id;
    logic [DW-1:0] sel_a, sel_b, sel_c, sel_x;
    logic          sel_mode, sel_last;
    logic          push, pop, underflow;

    logic          tag_mem [TAG_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          pop_tag;
    logic [RW-1:0] rsp_data;

    // Grant selection: round-robin among valid requesters, or the lock owner only.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves a latch behind.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_ARB) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end else begin
            grant0 = ~owner;
            grant1 = owner;
        end
    end

    // Ready looks at the FIFO count only; a same-cycle pop does not open it.
    assign room           = (count < CW'(TAG_DEPTH));
    assign bus.req0_ready = grant0 & room & ~reset;
    assign bus.req1_ready = grant1 & room & ~reset;

    assign acc0   = bus.req0_valid & bus.req0_ready;
    assign acc1   = bus.req1_valid & bus.req1_ready;
    assign accept = acc0 | acc1;
    assign sel_id = acc1;

    assign sel_a    = sel_id ? bus.req1_a    : bus.req0_a;
    assign sel_b    = sel_id ? bus.req1_b    : bus.req0_b;
    assign sel_c    = sel_id ? bus.req1_c    : bus.req0_c;
    assign sel_x    = sel_id ? bus.req1_x    : bus.req0_x;
    assign sel_mode = sel_id ? bus.req1_mode : bus.req0_mode;
    assign sel_last = sel_id ? bus.req1_last : bus.req0_last;

    // Only mode-0 beats and the closing MAC beat produce a QE_M result.
    assign push      = accept & (~sel_mode | sel_last);
    assign pop       = bus.qe_valid_out & (count != '0);
    assign underflow = bus.qe_valid_out & (count == '0);
    assign pop_tag   = tag_mem[rd_ptr];
    assign rsp_data  = bus.qe_result;

    // Next-state logic: enter LOCK on an open MAC beat, leave it on the owner's last beat.
    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        owner_d      = owner;
        case (state)
            ST_ARB: begin
                if (accept) begin
                    if (sel_mode && !sel_last) begin
                        owner_d = sel_id;
                        state_d = ST_LOCK;
                    end else begin
                        last_grant_d = sel_id;
                    end
                end
            end
            ST_LOCK: begin
                // A mode-0 beat from the owner is issued but does not release the lock.
                if (accept && sel_mode && sel_last) begin
                    last_grant_d = owner;
                    state_d      = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // State register; last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is written with <= so every flop samples pre-edge values.
        if (reset) begin
            state      <= ST_ARB;
            last_grant <= 1'b1;
            owner      <= 1'b0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            owner      <= owner_d;
        end
    end

    // Issue register: accepted beat reaches QE_M one cycle later; operands hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.qe_valid_in   <= 1'b0;
            bus.qe_last_input <= 1'b0;
            bus.qe_mode       <= 1'b0;
            bus.qe_a          <= '0;
            bus.qe_b          <= '0;
            bus.qe_c          <= '0;
            bus.qe_x          <= '0;
        end else begin
            bus.qe_valid_in   <= accept;
            bus.qe_last_input <= accept & sel_mode & sel_last;
            if (accept) begin
                bus.qe_mode <= sel_mode;
                bus.qe_a    <= sel_a;
                bus.qe_b    <= sel_b;
                bus.qe_c    <= sel_c;
                bus.qe_x    <= sel_x;
            end
        end
    end

    // Tag storage: pointers and count carry all the state, so the slots need no reset.
    always_ff @(posedge clk) begin
        // NOTE: memory contents stay unreset; a slot is only read after it has been written.
        if (push) begin
            tag_mem[wr_ptr] <= sel_id;
        end
    end

    // Tag FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(TAG_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(TAG_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Response routing: one-cycle pulse to the tagged requester; sticky underflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rsp0_valid    <= 1'b0;
            bus.rsp1_valid    <= 1'b0;
            bus.rsp0_result   <= '0;
            bus.rsp1_result   <= '0;
            bus.err_underflow <= 1'b0;
        end else begin
            bus.rsp0_valid    <= pop & ~pop_tag;
            bus.rsp1_valid    <= pop & pop_tag;
            if (pop && !pop_tag) begin
                bus.rsp0_result <= rsp_data;
            end
            if (pop && pop_tag) begin
                bus.rsp1_result <= rsp_data;
            end
            bus.err_underflow <= bus.err_underflow | underflow;
        end
    end
endmodule

// File: tb/tb_qe_m_arbiter.sv
// Self-checking bench for qe_m_arbiter: directed scenarios followed by a
// randomized phase. A transaction-level model predicts ready, issue and
// response behaviour; a small QE_M model answers issued beats.
module tb_qe_m_arbiter;
    localparam int DW    = 8;
    localparam int RW    = 16;
    localparam int DEPTH = 2;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        logic [DW-1:0] x;
        logic          mode;
        logic          last;
    } beat_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    qe_m_arbiter_if #(.DW(DW), .RW(RW)) bus ();

    qe_m_arbiter #(.DW(DW), .RW(RW), .TAG_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // stimulus sources
    beat_t         srcq [2][$];
    bit            en [2];

    // transaction-level reference model
    int            lock_owner;
    int            last_win;
    int            cnt;
    int            tagq [$];
    logic [RW-1:0] rspq [2][$];
    logic [RW-1:0] macacc [2];
    bit            exp_iss_valid;
    beat_t         exp_iss;
    bit            exp_rsp_v [2];
    logic [RW-1:0] exp_rsp_r [2];
    bit            exp_err;

    // QE_M environment model
    logic [RW-1:0] pend [$];
    logic [RW-1:0] qe_acc;
    bit            hold, release_one, inject;

    // observed response log
    int            rsp_log [$];
    logic [RW-1:0] last_seen [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input int a, input int b, input int c, input int x,
                                 input bit mode, input bit last);
        beat_t bt;
        bt.a = DW'(a); bt.b = DW'(b); bt.c = DW'(c); bt.x = DW'(x);
        bt.mode = mode; bt.last = last;
        return bt;
    endfunction

    function automatic logic [RW-1:0] poly(input beat_t bt);
        int a = int'(bt.a);
        int b = int'(bt.b);
        int c = int'(bt.c);
        int x = int'(bt.x);
        return RW'(a * x * x + b * x + c);
    endfunction

    task automatic drive_idle();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_c = '0;
        bus.req0_x = '0; bus.req0_mode = 1'b0; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_c = '0;
        bus.req1_x = '0; bus.req1_mode = 1'b0; bus.req1_last = 1'b0;
        bus.qe_valid_out = 1'b0; bus.qe_result = '0;
    endtask

    // One clock cycle: entered and left at posedge+1, checks at the negedge.
    task automatic cycle();
        bit            v [2];
        bit            pr [2];
        beat_t         cur [2];
        beat_t         bt;
        bit            qv;
        logic [RW-1:0] qr;
        logic [RW-1:0] res;
        int            t;

        for (int n = 0; n < 2; n++) begin
            v[n]   = en[n] && (srcq[n].size() > 0);
            cur[n] = v[n] ? srcq[n][0] : mk(0, 0, 0, 0, 1'b0, 1'b0);
        end
        bus.req0_valid = v[0]; bus.req0_a = cur[0].a; bus.req0_b = cur[0].b;
        bus.req0_c = cur[0].c; bus.req0_x = cur[0].x;
        bus.req0_mode = cur[0].mode; bus.req0_last = cur[0].last;
        bus.req1_valid = v[1]; bus.req1_a = cur[1].a; bus.req1_b = cur[1].b;
        bus.req1_c = cur[1].c; bus.req1_x = cur[1].x;
        bus.req1_mode = cur[1].mode; bus.req1_last = cur[1].last;

        qv = 1'b0;
        qr = '0;
        if (inject) begin
            qv = 1'b1; qr = 16'hBEEF; inject = 1'b0;
        end else if (pend.size() > 0 && (!hold || release_one)) begin
            qv = 1'b1; qr = pend.pop_front(); release_one = 1'b0;
        end
        bus.qe_valid_out = qv;
        bus.qe_result    = qr;

        #4;
        // predicted handshake from the arbitration rules
        for (int n = 0; n < 2; n++) begin
            if (lock_owner >= 0) pr[n] = (n == lock_owner);
            else                 pr[n] = v[n] && (!v[1 - n] || last_win != n);
            pr[n] = pr[n] && (cnt < DEPTH);
        end
        chk("req0_ready", 32'(bus.req0_ready), 32'(pr[0]));
        chk("req1_ready", 32'(bus.req1_ready), 32'(pr[1]));
        chk("qe_valid_in", 32'(bus.qe_valid_in), 32'(exp_iss_valid));
        if (exp_iss_valid) begin
            chk("qe_operands", {bus.qe_a, bus.qe_b, bus.qe_c, bus.qe_x},
                {exp_iss.a, exp_iss.b, exp_iss.c, exp_iss.x});
            chk("qe_mode_last", 32'({bus.qe_mode, bus.qe_last_input}),
                32'({exp_iss.mode, exp_iss.mode & exp_iss.last}));
        end else begin
            chk("qe_last_idle", 32'(bus.qe_last_input), 32'(0));
        end
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(exp_rsp_v[0]));
        if (exp_rsp_v[0]) chk("rsp0_result", 32'(bus.rsp0_result), 32'(exp_rsp_r[0]));
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(exp_rsp_v[1]));
        if (exp_rsp_v[1]) chk("rsp1_result", 32'(bus.rsp1_result), 32'(exp_rsp_r[1]));
        chk("err_underflow", 32'(bus.err_underflow), 32'(exp_err));

        if (bus.rsp0_valid) begin rsp_log.push_back(0); last_seen[0] = bus.rsp0_result; end
        if (bus.rsp1_valid) begin rsp_log.push_back(1); last_seen[1] = bus.rsp1_result; end

        // QE_M model reacts to whatever the arbiter issued
        if (bus.qe_valid_in) begin
            if (!bus.qe_mode) begin
                pend.push_back(RW'(int'(bus.qe_a) * int'(bus.qe_x) * int'(bus.qe_x)
                                   + int'(bus.qe_b) * int'(bus.qe_x) + int'(bus.qe_c)));
            end else begin
                qe_acc = qe_acc + RW'(int'(bus.qe_a) * int'(bus.qe_x));
                if (bus.qe_last_input) begin
                    pend.push_back(qe_acc);
                    qe_acc = '0;
                end
            end
        end

        // reference model advances across the coming edge
        exp_iss_valid = 1'b0;
        exp_rsp_v[0]  = 1'b0;
        exp_rsp_v[1]  = 1'b0;
        if (qv) begin
            if (cnt > 0) begin
                t = tagq.pop_front();
                exp_rsp_v[t] = 1'b1;
                exp_rsp_r[t] = rspq[t].pop_front();
                cnt--;
            end else begin
                exp_err = 1'b1;
            end
        end
        for (int n = 0; n < 2; n++) begin
            if (v[n] && pr[n]) begin
                bt = srcq[n].pop_front();
                exp_iss       = bt;
                exp_iss_valid = 1'b1;
                if (!bt.mode) begin
                    if (lock_owner < 0) last_win = n;
                    tagq.push_back(n); rspq[n].push_back(poly(bt)); cnt++;
                end else begin
                    macacc[n] = macacc[n] + RW'(int'(bt.a) * int'(bt.x));
                    if (bt.last) begin
                        res = macacc[n];
                        macacc[n] = '0;
                        lock_owner = -1;
                        last_win = n;
                        tagq.push_back(n); rspq[n].push_back(res); cnt++;
                    end else begin
                        lock_owner = n;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_ctrl", 32'({bus.req0_ready, bus.req1_ready, bus.qe_valid_in, bus.qe_last_input,
                             bus.qe_mode, bus.rsp0_valid, bus.rsp1_valid, bus.err_underflow}), 32'(0));
        chk("rst_qe_ops", {bus.qe_a, bus.qe_b, bus.qe_c, bus.qe_x}, 32'(0));
        chk("rst_rsp", {bus.rsp0_result, bus.rsp1_result}, 32'(0));
        lock_owner = -1; last_win = 1; cnt = 0; exp_iss_valid = 1'b0; exp_err = 1'b0;
        tagq.delete(); pend.delete(); qe_acc = '0;
        hold = 1'b0; release_one = 1'b0; inject = 1'b0;
        for (int n = 0; n < 2; n++) begin
            rspq[n].delete(); srcq[n].delete();
            macacc[n] = '0; exp_rsp_v[n] = 1'b0; en[n] = 1'b1;
        end
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_until_idle(input int bound, input string tag);
        int k = 0;
        while (k < bound && (srcq[0].size() > 0 || srcq[1].size() > 0 || cnt > 0 || pend.size() > 0
                             || exp_iss_valid || exp_rsp_v[0] || exp_rsp_v[1])) begin
            cycle();
            k++;
        end
        chk({tag, "_bound"}, 32'(k < bound), 32'(1));
    endtask

    task automatic gen_txn(input int n);
        int len;
        if ($urandom_range(0, 1) == 0) begin
            srcq[n].push_back(mk($urandom_range(0, 255), $urandom_range(0, 255),
                                 $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1'b0));
        end else begin
            len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) begin
                srcq[n].push_back(mk($urandom_range(0, 255), $urandom_range(0, 255),
                                     $urandom_range(0, 255), $urandom_range(0, 255), 1'b1, j == len - 1));
            end
        end
    endtask

    initial begin
        drive_idle();
        @(posedge clk);
        #1;
        do_reset();

        // T1: single mode-0 beat from requester 0
        rsp_log.delete();
        srcq[0].push_back(mk(100, 5, 25, 8, 1'b0, 1'b0));
        run_until_idle(20, "t1");
        chk("t1_rsp_count", rsp_log.size(), 1);
        chk("t1_rsp_id", (rsp_log.size() > 0) ? rsp_log[0] : 99, 0);
        chk("t1_result", 32'(last_seen[0]), 32'(6465));

        // T2: contention after reset, requester 0 first, then alternation
        do_reset();
        rsp_log.delete();
        srcq[0].push_back(mk(1, 0, 0, 2, 1'b0, 1'b0));
        srcq[0].push_back(mk(0, 0, 7, 0, 1'b0, 1'b0));
        srcq[1].push_back(mk(0, 0, 3, 0, 1'b0, 1'b0));
        run_until_idle(30, "t2");
        chk("t2_rsp_count", rsp_log.size(), 3);
        chk("t2_order", (rsp_log.size() == 3) ? (rsp_log[0] * 4 + rsp_log[1] * 2 + rsp_log[2]) : 99, 2);
        chk("t2_rsp1", 32'(last_seen[1]), 32'(3));
        chk("t2_rsp0_last", 32'(last_seen[0]), 32'(7));

        // T3: requester 1 MAC sequence holds the lock against requester 0
        rsp_log.delete();
        srcq[1].push_back(mk(100, 0, 0, 8, 1'b1, 1'b0));
        srcq[1].push_back(mk(20, 0, 0, 3, 1'b1, 1'b0));
        srcq[1].push_back(mk(1, 0, 0, 2, 1'b1, 1'b1));
        srcq[0].push_back(mk(2, 0, 0, 3, 1'b0, 1'b0));
        run_until_idle(30, "t3");
        chk("t3_order", (rsp_log.size() == 2) ? (rsp_log[0] * 2 + rsp_log[1]) : 99, 2);
        chk("t3_mac_result", 32'(last_seen[1]), 32'(862));

        // T4: tag FIFO full blocks requester 0 until one result returns
        hold = 1'b1;
        srcq[0].push_back(mk(1, 1, 1, 1, 1'b0, 1'b0));
        srcq[0].push_back(mk(2, 2, 2, 2, 1'b0, 1'b0));
        srcq[0].push_back(mk(3, 3, 3, 3, 1'b0, 1'b0));
        repeat (6) cycle();
        release_one = 1'b1;
        repeat (4) cycle();
        hold = 1'b0;
        run_until_idle(30, "t4");

        // T5: reset in the middle of a MAC sequence
        srcq[1].push_back(mk(100, 0, 0, 8, 1'b1, 1'b0));
        srcq[1].push_back(mk(20, 0, 0, 3, 1'b1, 1'b0));
        srcq[1].push_back(mk(1, 0, 0, 2, 1'b1, 1'b1));
        srcq[0].push_back(mk(2, 0, 0, 3, 1'b0, 1'b0));
        begin
            int k = 0;
            while (srcq[1].size() > 1 && k < 20) begin
                cycle();
                k++;
            end
            chk("t5_bound", 32'(k < 20), 32'(1));
        end
        #2;
        do_reset();
        rsp_log.delete();
        srcq[0].push_back(mk(3, 0, 1, 2, 1'b0, 1'b0));
        srcq[1].push_back(mk(0, 0, 9, 0, 1'b0, 1'b0));
        run_until_idle(20, "t5");
        chk("t5_first_winner", (rsp_log.size() > 0) ? rsp_log[0] : 99, 0);

        // T6: result with no tag outstanding
        rsp_log.delete();
        inject = 1'b1;
        repeat (4) cycle();
        chk("t6_err_held", 32'(bus.err_underflow), 32'(1));
        chk("t6_no_rsp", rsp_log.size(), 0);
        do_reset();

        // randomized traffic with random QE_M stalls
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 2; n++) begin
                en[n] = ($urandom_range(0, 3) != 0);
                if (srcq[n].size() == 0 && $urandom_range(0, 2) == 0) gen_txn(n);
            end
            hold = ($urandom_range(0, 3) == 0);
            cycle();
        end
        hold  = 1'b0;
        en[0] = 1'b1;
        en[1] = 1'b1;
        run_until_idle(200, "rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
